cordic_vec_sequencer: RTL

Iterative CORDIC vectoring controller that time-multiplexes one combinational micro-rotation unit over N cycles instead of N pipelined stages. Accepts signed (x,y) over a valid/ready handshake and does a quadrant pre-rotation. Sequences the N iterations from an arctangent table and returns magnitude R and angle theta in centidegrees over a valid/ready handshake. Sits between the sample source and downstream magnitude/phase consumers wherever area matters more than throughput.

---
 rtl/cordic_pkg.sv | 29 ++
 rtl/cordic_vec_micro.sv | 30 +++
 rtl/cordic_vec_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and types for the iterative CORDIC vectoring sequencer.
// Angles are signed centidegrees (4500 = 45.00 deg).
package cordic_pkg;

    localparam int ANG_W = 16;
    localparam int ATAN_N = 8;

    localparam logic signed [ANG_W-1:0] ATAN_TABLE [ATAN_N] = '{
        16'sd4500, 16'sd2657, 16'sd1404, 16'sd713,
        16'sd358,  16'sd179,  16'sd90,   16'sd45
    };

    localparam logic signed [ANG_W-1:0] ANG_P90 = 16'sd9000;
    localparam logic signed [ANG_W-1:0] ANG_M90 = -16'sd9000;

    // R * (1/2 + 1/8 - 1/64 - 1/512) ~= R * 0.6074, cancelling the CORDIC gain
    localparam int GC_SH0 = 1;
    localparam int GC_SH1 = 3;
    localparam int GC_SH2 = 6;
    localparam int GC_SH3 = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/cordic_vec_micro.sv
// One combinational CORDIC vectoring micro-rotation, driving y toward zero.
// Both updates use the incoming x/y; shifts are arithmetic.
module cordic_vec_micro
    import cordic_pkg::*;
#(
    parameter int XW = 18
) (
    input  logic signed [XW-1:0]    i_x,
    input  logic signed [XW-1:0]    i_y,
    input  logic signed [ANG_W-1:0] i_z,
    input  logic [2:0]              i_shift,
    input  logic signed [ANG_W-1:0] i_atan,
    output logic signed [XW-1:0]    o_x,
    output logic signed [XW-1:0]    o_y,
    output logic signed [ANG_W-1:0] o_z
);

    logic                 w_y_neg;
    logic signed [XW-1:0] w_xs;
    logic signed [XW-1:0] w_ys;

    assign w_y_neg = i_y[XW-1];
    assign w_xs    = i_x >>> i_shift;
    assign w_ys    = i_y >>> i_shift;

    assign o_x = w_y_neg ? (i_x - w_ys) : (i_x + w_ys);
    assign o_y = w_y_neg ? (i_y + w_xs) : (i_y - w_xs);
    assign o_z = w_y_neg ? (i_z - i_atan) : (i_z + i_atan);

endmodule

// File: rtl/cordic_vec_sequencer.sv
// Iterative CORDIC vectoring engine: one shared micro-rotation reused over N
// cycles, returning magnitude and angle (centidegrees) over valid/ready.
//
// state | meaning
// IDLE  | waiting for a sample, in_ready=1
// PRE   | quadrant pre-rotation into the right half-plane
// ITER  | micro-rotation i = 0..N-1
// DONE  | first cycle loads result regs; then holds out_valid until accepted
module cordic_vec_sequencer
    import cordic_pkg::*;
#(
    parameter int W         = 16,
    parameter int N         = 8,
    parameter int GAIN_COMP = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [W-1:0]     xi,
    input  logic signed [W-1:0]     yi,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [W+1:0]     r_out,
    output logic signed [ANG_W-1:0] theta_out,
    output logic                    busy
);

    localparam int XW = W + 2;
    localparam logic [2:0] I_LAST = 3'(N - 1);

    state_t                  r_state;
    logic signed [XW-1:0]    r_x;
    logic signed [XW-1:0]    r_y;
    logic signed [ANG_W-1:0] r_z;
    logic [2:0]              r_i;
    logic                    r_out_valid;
    logic                    r_busy;
    logic signed [XW-1:0]    r_r_out;
    logic signed [ANG_W-1:0] r_theta;

    logic signed [XW-1:0]    w_x_nxt;
    logic signed [XW-1:0]    w_y_nxt;
    logic signed [ANG_W-1:0] w_z_nxt;
    logic signed [XW-1:0]    w_r_comp;
    logic signed [XW-1:0]    w_xi_ext;
    logic signed [XW-1:0]    w_yi_ext;
    logic                    w_accept;

    cordic_vec_micro #(.XW(XW)) u_micro (
        .i_x     (r_x),
        .i_y     (r_y),
        .i_z     (r_z),
        .i_shift (r_i),
        .i_atan  (ATAN_TABLE[r_i]),
        .o_x     (w_x_nxt),
        .o_y     (w_y_nxt),
        .o_z     (w_z_nxt)
    );

    assign w_xi_ext = {{2{xi[W-1]}}, xi};
    assign w_yi_ext = {{2{yi[W-1]}}, yi};
    assign w_r_comp = (r_x >>> GC_SH0) + (r_x >>> GC_SH1)
                    - (r_x >>> GC_SH2) - (r_x >>> GC_SH3);

    // DONE only frees the engine once the loaded result is actually taken
    assign in_ready = (r_state == ST_IDLE)
                   || (r_state == ST_DONE && r_out_valid && out_ready);
    assign w_accept = in_valid && in_ready;

    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign r_out     = r_r_out;
    assign theta_out = r_theta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_i         <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_r_out     <= '0;
            r_theta     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_x     <= w_xi_ext;
                        r_y     <= w_yi_ext;
                        r_z     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (r_x[XW-1] && !r_y[XW-1]) begin
                        r_x <= r_y;
                        r_y <= -r_x;
                        r_z <= ANG_P90;
                    end else if (r_x[XW-1]) begin
                        r_x <= -r_y;
                        r_y <= r_x;
                        r_z <= ANG_M90;
                    end else begin
                        r_z <= '0;
                    end
                    r_i     <= '0;
                    r_state <= ST_ITER;
                end
                ST_ITER: begin
                    r_x <= w_x_nxt;
                    r_y <= w_y_nxt;
                    r_z <= w_z_nxt;
                    if (r_i == I_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_i <= r_i + 3'd1;
                    end
                end
                ST_DONE: begin
                    if (!r_out_valid) begin
                        r_r_out     <= (GAIN_COMP != 0) ? w_r_comp : r_x;
                        r_theta     <= r_z;
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (in_valid) begin
                            r_x     <= w_xi_ext;
                            r_y     <= w_yi_ext;
                            r_z     <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ST_PRE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
